// File: rtl/yuv422_to_tv.sv
// YUV422 word-to-byte serialiser for the 8-bit video link.
// Sends each 16-bit pixel low byte first and generates the matching hsync/vsync/frame envelope.
module yuv422_to_tv #(
   parameter int unsigned IMAGE_WIDE = 800,
   parameter int unsigned IMAGE_HIGH = 600,
   parameter int unsigned H_BLANK    = 300,
   parameter int unsigned V_BLANK    = 100
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_enable,
   input  logic        i_clr_err,
   input  logic [15:0] i_data,
   input  logic        i_sof,
   input  logic        i_valid,
   output logic        o_ready,
   output logic [7:0]  o_data,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_frame_done,
   output logic        o_underrun,
   output logic        o_sync_err
);
   localparam int unsigned HACT = 2 * IMAGE_WIDE;
   localparam int unsigned HNUM = HACT + H_BLANK;
   localparam int unsigned VNUM = IMAGE_HIGH + V_BLANK;
   localparam int unsigned HW   = $clog2(HNUM);
   localparam int unsigned VW   = $clog2(VNUM);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_SOF, S_RUN} state_t;

   state_t        r_state, w_state_nxt;
   logic [HW-1:0] r_hcnt;
   logic [VW-1:0] r_vcnt;
   logic [15:0]   r_word;
   logic          r_sof, r_full, r_pix_ok, r_first;
   logic [7:0]    r_data;
   logic          r_hsync, r_vsync, r_frame_done, r_underrun, r_sync_err;

   logic w_run, w_wait, w_vact, w_active, w_even, w_odd, w_origin, w_frame_end;
   logic w_sync_err, w_underrun, w_consume, w_ready, w_hs, w_load_sof;

   assign w_run       = (r_state == S_RUN);
   assign w_wait      = (r_state == S_WAIT_SOF);
   assign w_vact      = (r_vcnt < VW'(IMAGE_HIGH));
   assign w_active    = w_run && w_vact && (r_hcnt < HW'(HACT));
   assign w_even      = w_active && !r_hcnt[0];
   assign w_odd       = w_active && r_hcnt[0];
   assign w_origin    = (r_hcnt == '0) && (r_vcnt == '0);
   assign w_frame_end = w_run && (r_hcnt == HW'(HNUM - 1)) && (r_vcnt == VW'(VNUM - 1));

   // Head-of-queue SOF checks: missing at a later frame start, or present anywhere but the origin.
   assign w_sync_err  = (w_run && w_origin && !r_first && r_full && !r_sof) ||
                        (w_even && r_full && r_sof && !w_origin);
   assign w_underrun  = w_even && !r_full;
   // A pixel is retired only if it was actually on the wire at the preceding even slot.
   assign w_consume   = w_odd && r_pix_ok;
   assign w_ready     = w_wait || (w_run && (!r_full || w_consume));
   assign w_hs        = i_valid && w_ready;
   assign w_load_sof  = w_wait && w_hs && i_sof;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     if (i_enable) w_state_nxt = S_WAIT_SOF;
         S_WAIT_SOF: if (w_load_sof) w_state_nxt = S_RUN;
         S_RUN: begin
            if (w_sync_err)                    w_state_nxt = S_WAIT_SOF;
            else if (w_frame_end && !i_enable) w_state_nxt = S_IDLE;
         end
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   // Line/frame counters run only while RUN persists; any exit parks them at the origin.
   always_ff @(posedge i_clk) begin
      if (i_rst || !w_run || (w_state_nxt != S_RUN)) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
      end else if (r_hcnt == HW'(HNUM - 1)) begin
         r_hcnt <= '0;
         r_vcnt <= (r_vcnt == VW'(VNUM - 1)) ? '0 : r_vcnt + VW'(1);
      end else begin
         r_hcnt <= r_hcnt + HW'(1);
      end
   end

   // Single-entry holding register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_word <= '0;
         r_sof  <= 1'b0;
         r_full <= 1'b0;
      end else if (w_wait) begin
         if (w_load_sof) begin
            r_word <= i_data;
            r_sof  <= 1'b1;
            r_full <= 1'b1;
         end
      end else if (w_run) begin
         if (w_sync_err) begin
            r_full <= 1'b0;
         end else if (w_hs) begin
            r_word <= i_data;
            r_sof  <= i_sof;
            r_full <= 1'b1;
         end else if (w_consume) begin
            r_full <= 1'b0;
         end
      end else begin
         r_full <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pix_ok <= 1'b0;
         r_first  <= 1'b0;
      end else begin
         r_pix_ok <= w_even && r_full && !w_sync_err;
         if (w_load_sof)       r_first <= 1'b1;
         else if (w_frame_end) r_first <= 1'b0;
      end
   end

   // Output stage: one clock behind the counters, forced quiet outside a healthy RUN.
   always_ff @(posedge i_clk) begin
      if (i_rst || !w_run || w_sync_err) begin
         r_data       <= 8'h00;
         r_hsync      <= 1'b0;
         r_vsync      <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_hsync      <= w_active;
         r_vsync      <= w_vact;
         r_frame_done <= w_frame_end;
         if (w_even && r_full)       r_data <= r_word[7:0];
         else if (w_odd && r_pix_ok) r_data <= r_word[15:8];
         else                        r_data <= 8'h00;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_underrun <= 1'b0;
         r_sync_err <= 1'b0;
      end else begin
         if (w_underrun)     r_underrun <= 1'b1;
         else if (i_clr_err) r_underrun <= 1'b0;
         if (w_sync_err)     r_sync_err <= 1'b1;
         else if (i_clr_err) r_sync_err <= 1'b0;
      end
   end

   assign o_ready      = w_ready;
   assign o_data       = r_data;
   assign o_hsync      = r_hsync;
   assign o_vsync      = r_vsync;
   assign o_frame_done = r_frame_done;
   assign o_underrun   = r_underrun;
   assign o_sync_err   = r_sync_err;

endmodule
